vc_flow_scheduler: RTL and testbench

- Downstream counterpart of the QoS flow-control FSM: it consumes that FSM's per-VC `pause_stb`/`continue_stb` strobes plus its `init` and `error_full` status.
- Keeps a per-VC paused mask and round-robin pops the four source VC FIFOs into the single downstream egress path.
- Skips paused and empty VCs, stops popping when the egress side is full, and halts permanently on an overflow error.
- Sits between the VC FIFO bank and the egress FIFO of the QoS module.

---
 rtl/qos_pkg.sv | 15 +
 rtl/vc_flow_scheduler_rr_arbiter4.sv | 30 +++
 rtl/vc_flow_scheduler.sv | 97 +++++++++
 tb/tb_vc_flow_scheduler.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/qos_pkg.sv
// Shared definitions for the QoS flow-control slice:
// scheduler states, VC count and egress margin.
package qos_pkg;

  localparam int NUM_VC           = 4;
  localparam int EGRESS_AF_MARGIN = 2;

  typedef enum logic [1:0] {
    SCH_RESET = 2'd0,
    SCH_INIT  = 2'd1,
    SCH_RUN   = 2'd2,
    SCH_HALT  = 2'd3
  } sch_state_t;

endpackage

// File: rtl/vc_flow_scheduler_rr_arbiter4.sv
// Rotate-priority arbiter for four requesters.
// Search starts at ptr+1 and wraps modulo four.
module rr_arbiter4
  import qos_pkg::*;
(
  input  logic [NUM_VC-1:0] req,
  input  logic [1:0]        ptr,
  output logic [NUM_VC-1:0] gnt,
  output logic [1:0]        idx,
  output logic              any
);

  logic [1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = ptr;
    any  = 1'b0;
    cand = '0;
    for (int k = 1; k <= NUM_VC; k++) begin
      cand = ptr + 2'(k);
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/vc_flow_scheduler.sv
// Round-robin drain of four VC FIFOs into one egress FIFO,
// honouring per-VC pause/continue strobes from the QoS FSM.
module vc_flow_scheduler
  import qos_pkg::*;
#(
  parameter int DATA_W = 6
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     init,
  input  logic [NUM_VC-1:0]        error_full,
  input  logic [NUM_VC-1:0]        pause_stb,
  input  logic [NUM_VC-1:0]        continue_stb,
  input  logic [NUM_VC-1:0]        vc_empty,
  input  logic [NUM_VC*DATA_W-1:0] vc_data,
  input  logic                     egress_almost_full,
  output logic [NUM_VC-1:0]        vc_pop,
  output logic [DATA_W-1:0]        data_out,
  output logic                     valid_out,
  output logic [NUM_VC-1:0]        paused,
  output logic                     halted
);

  sch_state_t state, state_nx;

  logic [1:0]        rr_ptr;
  logic [NUM_VC-1:0] elig;
  logic [NUM_VC-1:0] gnt;
  logic [1:0]        gnt_idx;
  logic              gnt_any;
  logic              arb_en;
  logic              pop;
  logic              pop_d;
  logic [1:0]        lane_d;
  logic [NUM_VC-1:0] paused_nx;

  always_ff @(posedge CLK) begin
    if (reset) state <= SCH_RESET;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      SCH_RESET: state_nx = SCH_INIT;
      SCH_INIT:  state_nx = init ? SCH_INIT : SCH_RUN;
      SCH_RUN:   state_nx = |error_full ? SCH_HALT : SCH_RUN;
      SCH_HALT:  state_nx = SCH_HALT;
      default:   state_nx = SCH_RESET;
    endcase
  end

  assign elig = ~vc_empty & ~paused;

  rr_arbiter4 u_arb (
    .req (elig),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  // Popping during a reset cycle would drop a word on the floor.
  assign arb_en = (state == SCH_RUN) & ~egress_almost_full & ~reset;
  assign vc_pop = arb_en ? gnt : '0;
  assign pop    = arb_en & gnt_any;

  always_comb begin
    paused_nx = '0;
    if (state == SCH_RUN || state == SCH_HALT)
      paused_nx = (paused & ~continue_stb) | pause_stb;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      paused    <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      halted    <= 1'b0;
      rr_ptr    <= 2'd3;
      pop_d     <= 1'b0;
      lane_d    <= '0;
    end else begin
      paused    <= paused_nx;
      halted    <= (state_nx == SCH_HALT);
      valid_out <= pop_d;
      if (pop_d)
        data_out <= vc_data[lane_d*DATA_W +: DATA_W];
      pop_d <= pop;
      if (pop) begin
        lane_d <= gnt_idx;
        rr_ptr <= gnt_idx;
      end
    end
  end

endmodule

// File: tb/tb_vc_flow_scheduler.sv
// Bench for vc_flow_scheduler: directed vector table, a reset
// sequence, then random traffic against a reference model.
module tb_vc_flow_scheduler;

  localparam int DW = 6;

  logic          CLK = 1'b0;
  logic          reset;
  logic          init;
  logic [3:0]    error_full;
  logic [3:0]    pause_stb;
  logic [3:0]    continue_stb;
  logic [3:0]    vc_empty;
  logic [4*DW-1:0] vc_data;
  logic          egress_almost_full;
  logic [3:0]    vc_pop;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic [3:0]    paused;
  logic          halted;

  vc_flow_scheduler #(.DATA_W(DW)) dut (
    .CLK                (CLK),
    .reset              (reset),
    .init               (init),
    .error_full         (error_full),
    .pause_stb          (pause_stb),
    .continue_stb       (continue_stb),
    .vc_empty           (vc_empty),
    .vc_data            (vc_data),
    .egress_almost_full (egress_almost_full),
    .vc_pop             (vc_pop),
    .data_out           (data_out),
    .valid_out          (valid_out),
    .paused             (paused),
    .halted             (halted)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: mode 0=reset 1=init 2=run 3=halt.
  int       m_mode = 0;
  bit [3:0] m_paused = '0;
  int       m_ptr = 3;
  bit       m_fl = 0;
  int       m_fl_lane = 0;
  bit       m_valid = 0;
  bit [5:0] m_data = '0;

  function automatic int m_grant();
    int i;
    if (reset || m_mode != 2 || egress_almost_full) return -1;
    for (int k = 1; k <= 4; k++) begin
      i = (m_ptr + k) % 4;
      if (!vc_empty[i] && !m_paused[i]) return i;
    end
    return -1;
  endfunction

  function automatic bit [3:0] m_pop_vec();
    int g;
    bit [3:0] v;
    g = m_grant();
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  task automatic model_upd();
    int g;
    g = m_grant();
    if (reset) begin
      m_mode = 0; m_paused = '0; m_ptr = 3;
      m_fl = 0; m_valid = 0; m_data = '0;
    end else begin
      m_valid = m_fl;
      if (m_fl) m_data = vc_data[m_fl_lane*DW +: DW];
      m_fl = (g >= 0);
      if (g >= 0) begin
        m_fl_lane = g;
        m_ptr = g;
      end
      if (m_mode >= 2) begin
        for (int i = 0; i < 4; i++)
          if (pause_stb[i]) m_paused[i] = 1;
          else if (continue_stb[i]) m_paused[i] = 0;
      end else m_paused = '0;
      case (m_mode)
        0: m_mode = 1;
        1: m_mode = init ? 1 : 2;
        2: m_mode = (|error_full) ? 3 : 2;
        default: m_mode = 3;
      endcase
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_upd();
    #1;
  endtask

  typedef struct {
    logic       init;
    logic [3:0] ps;
    logic [3:0] cs;
    logic       af;
    logic [3:0] err;
    logic [3:0] pop;
    logic       vld;
    logic [5:0] dat;
    logic [3:0] pau;
    logic       hlt;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic i, input logic [3:0] ps,
                     input logic [3:0] cs, input logic af,
                     input logic [3:0] err, input logic [3:0] pop,
                     input logic vld, input logic [5:0] dat,
                     input logic [3:0] pau, input logic hlt);
    vec_t v;
    v = '{i, ps, cs, af, err, pop, vld, dat, pau, hlt};
    tv.push_back(v);
  endtask

  localparam logic [4*DW-1:0] TBL_DATA =
    {6'd13, 6'd12, 6'd11, 6'd10};

  initial begin
    reset = 1; init = 1; error_full = '0; pause_stb = '0;
    continue_stb = '0; vc_empty = '0; vc_data = TBL_DATA;
    egress_almost_full = 0;

    //  init ps     cs     af err    pop    v dat pau    h
    add(1, 4'h0, 4'h0, 0, 4'h0, 4'b0000, 0, 0,  4'h0, 0);
    add(1, 4'h0, 4'h0, 0, 4'h0, 4'b0000, 0, 0,  4'h0, 0);
    add(1, 4'h0, 4'h0, 0, 4'h0, 4'b0000, 0, 0,  4'h0, 0);
    add(1, 4'h0, 4'h0, 0, 4'h0, 4'b0000, 0, 0,  4'h0, 0);
    add(0, 4'h0, 4'h0, 0, 4'h0, 4'b0000, 0, 0,  4'h0, 0);
    add(0, 4'h0, 4'h0, 0, 4'h0, 4'b0001, 0, 0,  4'h0, 0);
    add(0, 4'h0, 4'h0, 0, 4'h0, 4'b0010, 0, 0,  4'h0, 0);
    add(0, 4'h0, 4'h0, 0, 4'h0, 4'b0100, 1, 10, 4'h0, 0);
    add(0, 4'h0, 4'h0, 0, 4'h0, 4'b1000, 1, 11, 4'h0, 0);
    add(0, 4'h0, 4'h0, 0, 4'h0, 4'b0001, 1, 12, 4'h0, 0);
    add(0, 4'h0, 4'h0, 0, 4'h0, 4'b0010, 1, 13, 4'h0, 0);
    add(0, 4'h4, 4'h0, 0, 4'h0, 4'b0100, 1, 10, 4'h0, 0);
    add(0, 4'h0, 4'h0, 0, 4'h0, 4'b1000, 1, 11, 4'h4, 0);
    add(0, 4'h0, 4'h0, 0, 4'h0, 4'b0001, 1, 12, 4'h4, 0);
    add(0, 4'h0, 4'h0, 0, 4'h0, 4'b0010, 1, 13, 4'h4, 0);
    add(0, 4'h0, 4'h0, 0, 4'h0, 4'b1000, 1, 10, 4'h4, 0);
    add(0, 4'h0, 4'h4, 0, 4'h0, 4'b0001, 1, 11, 4'h4, 0);
    add(0, 4'h0, 4'h0, 0, 4'h0, 4'b0010, 1, 13, 4'h0, 0);
    add(0, 4'h0, 4'h0, 0, 4'h0, 4'b0100, 1, 10, 4'h0, 0);
    add(0, 4'h1, 4'h1, 0, 4'h0, 4'b1000, 1, 11, 4'h0, 0);
    add(0, 4'h0, 4'h0, 0, 4'h0, 4'b0010, 1, 12, 4'h1, 0);
    add(0, 4'h0, 4'h0, 1, 4'h0, 4'b0000, 1, 13, 4'h1, 0);
    add(0, 4'h0, 4'h0, 1, 4'h0, 4'b0000, 1, 11, 4'h1, 0);
    add(0, 4'h0, 4'h0, 1, 4'h0, 4'b0000, 0, 11, 4'h1, 0);
    add(0, 4'h0, 4'h0, 1, 4'h0, 4'b0000, 0, 11, 4'h1, 0);
    add(0, 4'h0, 4'h0, 0, 4'h0, 4'b0100, 0, 11, 4'h1, 0);
    add(0, 4'h0, 4'h0, 0, 4'h2, 4'b1000, 0, 11, 4'h1, 0);
    add(0, 4'h0, 4'h0, 0, 4'h0, 4'b0000, 1, 12, 4'h1, 1);
    add(0, 4'h0, 4'h0, 0, 4'h0, 4'b0000, 1, 13, 4'h1, 1);
    add(0, 4'h0, 4'h0, 0, 4'h0, 4'b0000, 0, 13, 4'h1, 1);

    tick();
    tick();
    foreach (tv[i]) begin
      reset = 0;
      init = tv[i].init;
      pause_stb = tv[i].ps;
      continue_stb = tv[i].cs;
      egress_almost_full = tv[i].af;
      error_full = tv[i].err;
      @(negedge CLK);
      chk($sformatf("tbl%0d.pop", i), 32'(vc_pop), 32'(tv[i].pop));
      chk($sformatf("tbl%0d.valid", i), 32'(valid_out),
          32'(tv[i].vld));
      chk($sformatf("tbl%0d.data", i), 32'(data_out), 32'(tv[i].dat));
      chk($sformatf("tbl%0d.paused", i), 32'(paused), 32'(tv[i].pau));
      chk($sformatf("tbl%0d.halted", i), 32'(halted), 32'(tv[i].hlt));
      tick();
    end

    // Reset while words are in flight must not leak a stale word.
    pause_stb = '0; continue_stb = '0; error_full = '0;
    egress_almost_full = 0; init = 0; reset = 1;
    tick();
    reset = 0;
    tick();
    tick();
    pause_stb = 4'h2;
    @(negedge CLK);
    chk("rst_seq.pop_c", 32'(|vc_pop), 32'd1);
    tick();
    pause_stb = '0;
    @(negedge CLK);
    chk("rst_seq.pop_d", 32'(|vc_pop), 32'd1);
    chk("rst_seq.paused_d", 32'(paused), 32'h2);
    tick();
    reset = 1;
    tick();
    reset = 0;
    @(negedge CLK);
    chk("rst_seq.valid1", 32'(valid_out), 32'd0);
    chk("rst_seq.paused1", 32'(paused), 32'd0);
    chk("rst_seq.halted1", 32'(halted), 32'd0);
    chk("rst_seq.pop1", 32'(vc_pop), 32'd0);
    tick();
    @(negedge CLK);
    chk("rst_seq.valid2", 32'(valid_out), 32'd0);
    tick();

    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 149) == 0) ||
              (m_mode == 3 && $urandom_range(0, 19) == 0);
      init = ($urandom_range(0, 2) == 0);
      error_full = ($urandom_range(0, 99) == 0) ?
                   4'($urandom_range(1, 15)) : 4'h0;
      pause_stb = ($urandom_range(0, 5) == 0) ?
                  4'($urandom) : 4'h0;
      continue_stb = ($urandom_range(0, 4) == 0) ?
                     4'($urandom) : 4'h0;
      vc_empty = 4'($urandom);
      vc_data = 24'($urandom);
      egress_almost_full = ($urandom_range(0, 3) == 0);
      @(negedge CLK);
      chk("rnd.pop", 32'(vc_pop), 32'(m_pop_vec()));
      chk("rnd.valid", 32'(valid_out), 32'(m_valid));
      chk("rnd.data", 32'(data_out), 32'(m_data));
      chk("rnd.paused", 32'(paused), 32'(m_paused));
      chk("rnd.halted", 32'(halted), 32'(m_mode == 3));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
